// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL lock filter, retry/fault supervisor and staggered reset sequencer
// Optional lock-loss event counter enabled by defining PLL_LOCK_LOSS_CNT_EN.
module pll_lock_supervisor #(
  parameter int NUM_RST      = 4,
  parameter int LOCK_FILT    = 16,
  parameter int STAGGER      = 8,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int PLL_RST_LEN  = 16,
  parameter int MAX_RETRY    = 3,
  parameter int RW           = $clog2(MAX_RETRY + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked_i,
  output logic               pll_rst_o,
  output logic [NUM_RST-1:0] rst_n_o,
  output logic               ready_o,
  output logic               fault_o,
  output logic [RW-1:0]      retry_cnt_o,
  output logic [7:0]         loss_cnt_o
);

  localparam int SEQ_LEN = NUM_RST * STAGGER;
  localparam int CMAX_A  = (LOCK_TIMEOUT > PLL_RST_LEN) ? LOCK_TIMEOUT : PLL_RST_LEN;
  localparam int CMAX    = (CMAX_A > SEQ_LEN) ? CMAX_A : SEQ_LEN;
  localparam int CW      = $clog2(CMAX + 1);
  localparam int FW      = $clog2(LOCK_FILT + 1);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_SEQ,
    ST_RUN,
    ST_FAULT
  } state_e;

  logic [1:0]         sync_q;
  logic               lock_s;
  logic [FW-1:0]      filt_q, filt_d;
  logic               lock_f_q, lock_f_d;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [NUM_RST-1:0] rst_q, rst_d;

  assign lock_s = sync_q[1];

  // Filter saturates at LOCK_FILT so lock_f stays high while lock_s holds.
  always_comb begin
    filt_d = filt_q;
    if (!lock_s) begin
      filt_d = '0;
    end else if (filt_q != FW'(LOCK_FILT)) begin
      filt_d = filt_q + 1'b1;
    end
    lock_f_d = lock_s && (filt_d == FW'(LOCK_FILT));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    rst_d   = rst_q;
    case (state_q)
      ST_PLL_RST: begin
        rst_d = '0;
        if (cnt_q == CW'(PLL_RST_LEN - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_f_q) begin
          state_d = ST_SEQ;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 1'b1;
          cnt_d   = '0;
          state_d = (retry_d == RW'(MAX_RETRY)) ? ST_FAULT : ST_PLL_RST;
        end
      end
      ST_SEQ: begin
        if (!lock_f_q) begin
          rst_d   = '0;
          cnt_d   = '0;
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RW'(MAX_RETRY)) ? ST_FAULT : ST_PLL_RST;
        end else if (rst_q[NUM_RST-1]) begin
          state_d = ST_RUN;
          retry_d = '0;
          cnt_d   = '0;
        end else begin
          for (int i = 0; i < NUM_RST; i++) begin
            if (cnt_d == CW'((i + 1) * STAGGER)) rst_d[i] = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_f_q) begin
          rst_d   = '0;
          state_d = ST_PLL_RST;
        end
      end
      ST_FAULT: begin
        cnt_d = '0;
        rst_d = '0;
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
        rst_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      filt_q   <= '0;
      lock_f_q <= 1'b0;
      state_q  <= ST_PLL_RST;
      cnt_q    <= '0;
      retry_q  <= '0;
      rst_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], pll_locked_i};
      filt_q   <= filt_d;
      lock_f_q <= lock_f_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      rst_q    <= rst_d;
    end
  end

  assign pll_rst_o   = (state_q == ST_PLL_RST) || (state_q == ST_FAULT);
  assign ready_o     = (state_q == ST_RUN);
  assign fault_o     = (state_q == ST_FAULT);
  assign rst_n_o     = rst_q;
  assign retry_cnt_o = retry_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic       loss_ev;
  logic [7:0] loss_q, loss_d;

  assign loss_ev = ((state_q == ST_SEQ) || (state_q == ST_RUN)) && !lock_f_q;

  always_comb begin
    loss_d = loss_q;
    if (loss_ev && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) loss_q <= '0;
    else        loss_q <= loss_d;
  end

  assign loss_cnt_o = loss_q;
`else
  assign loss_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor
// Each output change is matched against a queued {cycle, output vector} expectation.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked_i = 1'b0;
  logic       pll_rst_o;
  logic [2:0] rst_n_o;
  logic       ready_o;
  logic       fault_o;
  logic [1:0] retry_cnt_o;
  logic [7:0] loss_cnt_o;

  pll_lock_supervisor #(
    .NUM_RST(3), .LOCK_FILT(4), .STAGGER(3),
    .LOCK_TIMEOUT(50), .PLL_RST_LEN(5), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked_i(pll_locked_i),
    .pll_rst_o(pll_rst_o), .rst_n_o(rst_n_o), .ready_o(ready_o),
    .fault_o(fault_o), .retry_cnt_o(retry_cnt_o), .loss_cnt_o(loss_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef PLL_LOCK_LOSS_CNT_EN
  localparam logic [7:0] LS = 8'd1;
`else
  localparam logic [7:0] LS = 8'd0;
`endif

  localparam logic [15:0] RST_VEC = {1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};

  typedef struct {
    int          cyc;
    logic [15:0] vec;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [15:0] mk(input logic pll, input logic [2:0] rn, input logic rdy,
                                     input logic flt, input logic [1:0] rc, input logic [7:0] lc);
    return {pll, rn, rdy, flt, rc, lc};
  endfunction

  task automatic expect_at(input string name, input int c, input logic [15:0] v);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  logic [15:0] prev = 'x;
  always @(negedge clk) begin : monitor
    logic [15:0] cur;
    exp_t        e;
    cur = {pll_rst_o, rst_n_o, ready_o, fault_o, retry_cnt_o, loss_cnt_o};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_change: got %h at cyc %0d, expected no change", cur, cyc);
      end else begin
        e = exp_q.pop_front();
        if (cur === e.vec && (e.cyc < 0 || e.cyc == cyc)) passed++;
        else $display("FAIL %s: got %h at cyc %0d, expected %h at cyc %0d",
                      e.name, cur, cyc, e.vec, e.cyc);
      end
      prev = cur;
    end
  end

  task automatic async_reset(input string name);
    @(posedge clk);
    #2;
    expect_at(name, cyc, RST_VEC);
    rst_n        = 1'b0;
    pll_locked_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int b;
    expect_at("reset_values", -1, RST_VEC);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Clean bring-up
    b = cyc;
    rst_n = 1'b1;
    expect_at("t1_pll_rst_len", b + 5, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0));
    repeat (14) @(negedge clk);
    b = cyc;
    pll_locked_i = 1'b1;
    expect_at("t1_rst0", b + 10, mk(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 8'd0));
    expect_at("t1_rst1", b + 13, mk(1'b0, 3'b011, 1'b0, 1'b0, 2'd0, 8'd0));
    expect_at("t1_rst2", b + 16, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0));
    expect_at("t1_ready", b + 17, mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0));
    repeat (22) @(negedge clk);

    // Loss in RUN, then automatic re-lock
    b = cyc;
    pll_locked_i = 1'b0;
    @(negedge clk);
    pll_locked_i = 1'b1;
    expect_at("t4_loss", b + 4, mk(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, LS));
    expect_at("t4_pll_rst_len", b + 9, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, LS));
    expect_at("t4_rst0", b + 13, mk(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, LS));
    expect_at("t4_rst1", b + 16, mk(1'b0, 3'b011, 1'b0, 1'b0, 2'd0, LS));
    expect_at("t4_rst2", b + 19, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, LS));
    expect_at("t4_ready", b + 20, mk(1'b0, 3'b111, 1'b1, 1'b0, 2'd0, LS));
    repeat (24) @(negedge clk);

    // Async reset between clock edges while in RUN
    async_reset("t6_async_reset");

    // Filter rejection, then timeout into fault
    b = cyc;
    rst_n = 1'b1;
    expect_at("t2_pll_rst_len", b + 5, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0));
    expect_at("t2_timeout", b + 55, mk(1'b1, 3'b000, 1'b0, 1'b0, 2'd1, 8'd0));
    expect_at("t3_retry_wait", b + 60, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 8'd0));
    expect_at("t3_fault", b + 110, mk(1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 8'd0));
    repeat (6) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      pll_locked_i = (i % 4) != 3;
      @(negedge clk);
    end
    pll_locked_i = 1'b0;
    repeat (70) @(negedge clk);
    pll_locked_i = 1'b1;
    repeat (20) @(negedge clk);

    // Two losses mid-SEQ exhaust the retries
    async_reset("t5_reset_from_fault");
    b = cyc;
    rst_n = 1'b1;
    expect_at("t5_pll_rst_len", b + 5, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0));
    repeat (6) @(negedge clk);
    pll_locked_i = 1'b1;
    expect_at("t5_rst0", b + 16, mk(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 8'd0));
    expect_at("t5_rst1", b + 19, mk(1'b0, 3'b011, 1'b0, 1'b0, 2'd0, 8'd0));
    repeat (11) @(negedge clk);
    pll_locked_i = 1'b0;
    expect_at("t5_seq_loss1", b + 21, mk(1'b1, 3'b000, 1'b0, 1'b0, 2'd1, LS));
    expect_at("t5_retry_wait", b + 26, mk(1'b0, 3'b000, 1'b0, 1'b0, 2'd1, LS));
    repeat (10) @(negedge clk);
    pll_locked_i = 1'b1;
    expect_at("t5_rst0_again", b + 37, mk(1'b0, 3'b001, 1'b0, 1'b0, 2'd1, LS));
    expect_at("t5_rst1_again", b + 40, mk(1'b0, 3'b011, 1'b0, 1'b0, 2'd1, LS));
    repeat (11) @(negedge clk);
    pll_locked_i = 1'b0;
    expect_at("t5_seq_loss_fault", b + 42, mk(1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 8'(LS + LS)));
    repeat (15) @(negedge clk);

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL pending_events: %0d expected changes never seen, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
